// File: rtl/wb_ctrl_pipe.sv
// wb_ctrl_pipe: writeback control stage.
//
// Decodes instruction words from the memory stage into register-file
// writeback controls. The controls travel through DEPTH register stages
// (DEPTH = 1..4) with stall and flush. All outputs are taken from the last
// stage.
//
// Parameters:
//   INSTR_W  instruction width. Opcode is in_ir[3:0]. Dest is in_ir[4+RA_W-1:4].
//   RA_W     register address width. The register file has 2**RA_W entries.
//   DEPTH    number of stages from input to outputs. Latency is DEPTH cycles.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-high reset
//   in_valid      in_ir holds a valid instruction this cycle
//   in_ir         instruction word
//   stall         hold all stages; the input is not accepted
//   flush         invalidate all stages; takes priority over stall
//   rf_write      register file write enable
//   reg_in        writeback data select (1 = memory data, 0 = ALU result)
//   r1_wb_sel     force the write destination to R1
//   wb_dest       write destination address (0 when the last stage is empty)
//   wb_valid      the last stage holds a valid instruction
//   pending_mask  bit i set = an in-flight instruction will write register i
//   retire_cnt    saturating count of retired instructions
//
// Build option:
//   WB_RETIRE_CNT_EN  when defined, builds the retire counter.
//                     When undefined, retire_cnt is tied to zero.
module wb_ctrl_pipe #(
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned RA_W    = 2,
    parameter int unsigned DEPTH   = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [INSTR_W-1:0]   in_ir,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 rf_write,
    output logic                 reg_in,
    output logic                 r1_wb_sel,
    output logic [RA_W-1:0]      wb_dest,
    output logic                 wb_valid,
    output logic [2**RA_W-1:0]   pending_mask,
    output logic [15:0]          retire_cnt
);

    localparam int unsigned LAST = DEPTH - 1;

    // Stage state: one bit per stage for each control flag, plus a dest array.
    logic [DEPTH-1:0] vld_q,   vld_d;
    logic [DEPTH-1:0] rfw_q,   rfw_d;
    logic [DEPTH-1:0] regin_q, regin_d;
    logic [DEPTH-1:0] r1_q,    r1_d;
    logic [RA_W-1:0]  dest_q [DEPTH];
    logic [RA_W-1:0]  dest_d [DEPTH];

    logic [3:0]      opcode;
    logic            dec_rfw;
    logic            dec_regin;
    logic            dec_r1;
    logic [RA_W-1:0] dec_dest;

    // Only the opcode and dest bits of in_ir are decoded. The remaining
    // bits are folded into this sink so they are not reported as dangling.
    logic unused_ir;
    assign unused_ir = ^in_ir;

    // Decode. The checks are evaluated in order; the first match wins.
    always_comb begin
        opcode    = in_ir[3:0];
        dec_rfw   = 1'b1;
        dec_regin = 1'b0;
        dec_r1    = 1'b0;
        if (opcode == 4'b0000) begin
            dec_regin = 1'b1;
        end else if (opcode == 4'b0010 || opcode == 4'b1010) begin
            dec_rfw   = 1'b0;
            dec_regin = 1'b1;
        end else if (opcode[2:0] == 3'b111) begin
            dec_r1    = 1'b1;
        end
        dec_dest = dec_r1 ? RA_W'(1) : in_ir[4 +: RA_W];
    end

    // Next-state for the stages. Flush clears only the valid bits. A stalled
    // cycle leaves every stage untouched and drops the input.
    always_comb begin
        vld_d   = vld_q;
        rfw_d   = rfw_q;
        regin_d = regin_q;
        r1_d    = r1_q;
        dest_d  = dest_q;
        if (flush) begin
            vld_d = '0;
        end else if (!stall) begin
            vld_d[0]   = in_valid;
            rfw_d[0]   = dec_rfw;
            regin_d[0] = dec_regin;
            r1_d[0]    = dec_r1;
            dest_d[0]  = dec_dest;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_d[i]   = vld_q[i-1];
                rfw_d[i]   = rfw_q[i-1];
                regin_d[i] = regin_q[i-1];
                r1_d[i]    = r1_q[i-1];
                dest_d[i]  = dest_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q   <= '0;
            rfw_q   <= '0;
            regin_q <= '0;
            r1_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            rfw_q   <= rfw_d;
            regin_q <= regin_d;
            r1_q    <= r1_d;
            dest_q  <= dest_d;
        end
    end

    // Outputs come only from last-stage flops and are gated by its valid bit.
    assign wb_valid  = vld_q[LAST];
    assign rf_write  = vld_q[LAST] & rfw_q[LAST];
    assign reg_in    = vld_q[LAST] & regin_q[LAST];
    assign r1_wb_sel = vld_q[LAST] & r1_q[LAST];
    assign wb_dest   = vld_q[LAST] ? dest_q[LAST] : '0;

    // If two stages target the same register, they set the same bit.
    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && rfw_q[i]) begin
                pending_mask[dest_q[i]] = 1'b1;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [15:0] retire_q, retire_d;

    // Count on every edge where the last stage leaves the pipe. Hold at the top value.
    always_comb begin
        retire_d = retire_q;
        if (!stall && !flush && vld_q[LAST] && retire_q != 16'hFFFF) begin
            retire_d = retire_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: doc/wb_ctrl_pipe.md
Name: wb_ctrl_pipe

Overview:
Parametrised writeback control stage for the pipelined processor. It accepts instruction words from the memory stage and decodes them into register-file writeback controls. It carries those controls through a configurable number of pipeline registers, with stall and flush support. It also exports a pending-write scoreboard mask that hazard logic uses to detect in-flight register writes.

Parameters:
INSTR_W, 8, instruction word width; opcode is in_ir[3:0], destination field is in_ir[4+RA_W-1:4]; INSTR_W >= 4+RA_W.
RA_W, 2, register address width; register file has 2**RA_W entries.
DEPTH, 1, number of register stages from input to outputs; legal range 1..4.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_ir holds a valid instruction this cycle
in_ir  input  INSTR_W  instruction word from the memory stage
stall  input  1  hold all stages; input not accepted
flush  input  1  invalidate all in-flight stages
rf_write  output  1  register file write enable
reg_in  output  1  writeback data select (1 = memory data, 0 = ALU result)
r1_wb_sel  output  1  force the write destination to R1
wb_dest  output  RA_W  write destination register address
wb_valid  output  1  last stage holds a valid instruction
pending_mask  output  2**RA_W  bit i set = a valid in-flight instruction will write register i
retire_cnt  output  16  count of retired instructions

Behaviour:
- Reset: synchronous, active-high. Clears all stage valid bits and the retire counter.
  - On the edge after reset, every output reads 0: rf_write, reg_in, r1_wb_sel, wb_dest, wb_valid, pending_mask, retire_cnt.
- Decode is combinational on in_ir and is captured into stage 0. Decode table (rfw, regin, r1sel):
  - opcode 0000 (load) -> 1,1,0
  - opcode 0010 (store) -> 0,1,0
  - opcode 1010 (nop) -> 0,1,0
  - opcode[2:0] = 111 (ori) -> 1,0,1
  - anything else -> 1,0,0
  - Priority is top to bottom.
- Destination:
  - Normally in_ir[4+RA_W-1:4].
  - When r1sel = 1, the stored dest is forced to 1.
- Pipeline: DEPTH stages. Each stage holds {valid, rfw, regin, r1sel, dest}.
  - Each clock with stall=0: stage 0 takes {in_valid, decode}; stage n takes stage n-1.
  - An instruction accepted at edge k appears on the outputs after edge k+DEPTH-1, so the latency is DEPTH cycles.
- Output gating: all outputs come from the last stage. They are registered, with no combinational path from inputs.
  - rf_write, reg_in and r1_wb_sel are each ANDed with the last-stage valid.
  - wb_dest reads 0 when the last stage is invalid.
  - wb_valid = last-stage valid.
- stall=1: every stage holds its value. in_valid is ignored and the instruction is dropped, so upstream must hold it. Outputs stay stable.
- flush=1: on the next edge all valid bits clear. in_valid is ignored on the same cycle. flush takes priority over stall.
- reset takes priority over flush and stall.
  - Reset mid-operation drops all in-flight instructions with no write.
- pending_mask: combinational OR, over all stages with valid & rfw, of onehot(dest).
  - Store and nop instructions never set bits.
  - Two stages with the same dest set a single bit.
- retire_cnt:
  - Increments on each edge where stall=0, flush=0 and the last stage is valid.
  - Saturates at 16'hFFFF with no wrap.

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined: the retire counter is implemented as described in Behaviour.
- Undefined: no counter flops are built and retire_cnt is tied to 16'h0000. All other behaviour is unchanged.

Test Plan:
1. DEPTH=1, apply reset, then load in_ir=8'h10 with in_valid=1 -> next cycle: rf_write=1, reg_in=1, r1_wb_sel=0, wb_dest=1, wb_valid=1.
2. DEPTH=3, issue ori (8'h37), then store (8'h22), then add (8'h25) on consecutive cycles ->
   - ori appears 3 cycles later: rf_write=1, r1_wb_sel=1, wb_dest=1.
   - Then store: rf_write=0, reg_in=1.
   - Then add: rf_write=1, wb_dest=2.
   - pending_mask peaks at 4'b0110.
3. DEPTH=2, two loads in flight, then assert stall for 3 cycles with in_valid=1 -> outputs and pending_mask frozen; no new instruction enters; outputs resume after stall drops.
4. DEPTH=3, three valid add instructions in flight, then assert flush together with stall -> next cycle: wb_valid=0, rf_write=0, pending_mask=0; retire_cnt unchanged.
5. Assert reset while two instructions are in flight -> next cycle all outputs read 0 and retire_cnt=0.
6. With WB_RETIRE_CNT_EN defined, preload the counter by issuing 65540 valid nops -> retire_cnt saturates at 16'hFFFF. With the macro undefined, retire_cnt stays 0.
